instance_output_merger: RTL and testbench

- N-to-1 AXI-Stream merger that collects the per-instance conflict_detection output streams back into one scheduler output stream.
- It is the return path of the round-robin input dispatcher.
- ORDERED=1 reads instances in strict round-robin order, so the original dispatch order is restored. ORDERED=0 runs work-conserving round-robin arbitration.
- Each output beat is tagged with its source instance. The block also keeps throughput, skip and stall counters.

---
 rtl/scheduler_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 45 ++++
 rtl/instance_output_merger.sv | 129 ++++++++++++
 tb/tb_instance_output_merger.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scheduler_pkg.sv
// Shared scheduler widths and the transaction record carried between the
// dispatcher, the conflict_detection instances and the output merger.
package scheduler_pkg;

    localparam int MAX_DEPENDENCIES_DEFAULT = 256;
    localparam int PROGRAM_ID_WIDTH         = 64;

    typedef struct packed {
        logic [PROGRAM_ID_WIDTH-1:0]         owner_programID;
        logic [MAX_DEPENDENCIES_DEFAULT-1:0] read_deps;
        logic [MAX_DEPENDENCIES_DEFAULT-1:0] write_deps;
    } transaction_t;

endpackage

// File: rtl/rr_arbiter.sv
// Work-conserving round-robin arbiter: searches from the slot after the last
// accepted grant and remembers the winner only when the grant is taken.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index
);

    logic [IW-1:0] last_grant;
    logic [IW-1:0] cand;
    logic          found;

    // N is a power of two, so the IW-bit add wraps the search modulo N.
    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = last_grant + IW'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
        grant = '0;
        if (enable && found) begin
            grant[index] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= '0;
        end else if (enable && found) begin
            last_grant <= index;
        end
    end

endmodule

// File: rtl/instance_output_merger.sv
// N-to-1 AXI-Stream merger returning per-instance conflict_detection results
// to a single scheduler stream, either in strict dispatch order or work-conserving.
module instance_output_merger
    import scheduler_pkg::*;
#(
    parameter  int NUM_PARALLEL_INSTANCES = 4,
    parameter  int MAX_DEPENDENCIES       = MAX_DEPENDENCIES_DEFAULT,
    parameter  int ORDERED                = 1,
    parameter  int SKIP_TIMEOUT_CYCLES    = 0,
    localparam int N  = NUM_PARALLEL_INSTANCES,
    localparam int IW = $clog2(NUM_PARALLEL_INSTANCES),
    localparam int PW = PROGRAM_ID_WIDTH,
    localparam int MD = MAX_DEPENDENCIES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    s_axis_tvalid,
    output logic [N-1:0]    s_axis_tready,
    input  logic [N*PW-1:0] s_axis_tdata_owner_programID,
    input  logic [N*MD-1:0] s_axis_tdata_read_dependencies,
    input  logic [N*MD-1:0] s_axis_tdata_write_dependencies,
    output logic            m_axis_tvalid,
    input  logic            m_axis_tready,
    output logic [PW-1:0]   m_axis_tdata_owner_programID,
    output logic [MD-1:0]   m_axis_tdata_read_dependencies,
    output logic [MD-1:0]   m_axis_tdata_write_dependencies,
    output logic [IW-1:0]   m_axis_tdest,
    output logic [31:0]     transactions_merged,
    output logic [31:0]     transactions_skipped,
    output logic [31:0]     output_stall_cycles
);

    localparam bit          SKIP_ENABLED = (ORDERED != 0) && (SKIP_TIMEOUT_CYCLES > 0);
    localparam logic [31:0] SKIP_LIMIT   = (SKIP_TIMEOUT_CYCLES > 0) ? 32'(SKIP_TIMEOUT_CYCLES - 1) : 32'd0;
    localparam logic [N-1:0] ONE_HOT0    = 1;

    logic [IW-1:0] ptr;
    logic [31:0]   wait_cnt;
    logic          slot_free;
    logic          grant_valid;
    logic [IW-1:0] grant_idx;
    logic          wait_cond;
    logic          skip;
    logic [N-1:0]  arb_grant;
    logic [IW-1:0] arb_index;

    assign slot_free = !m_axis_tvalid || m_axis_tready;

    rr_arbiter #(.N(N)) u_rr_arbiter (
        .clk    (clk),
        .rst    (rst),
        .req    (s_axis_tvalid),
        .enable ((ORDERED == 0) && slot_free),
        .grant  (arb_grant),
        .index  (arb_index)
    );

    // Starvation of the expected instance only counts while someone else is waiting.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = ptr;
        wait_cond   = 1'b0;
        skip        = 1'b0;
        if (ORDERED != 0) begin
            grant_valid = s_axis_tvalid[ptr] && slot_free;
            wait_cond   = SKIP_ENABLED && slot_free && !s_axis_tvalid[ptr]
                          && (|(s_axis_tvalid & ~(ONE_HOT0 << ptr)));
            skip        = wait_cond && (wait_cnt == SKIP_LIMIT);
        end else begin
            grant_valid = |arb_grant;
            grant_idx   = arb_index;
        end
        if (rst) begin
            grant_valid = 1'b0;
            skip        = 1'b0;
        end
        s_axis_tready = '0;
        if (grant_valid) begin
            s_axis_tready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tvalid                   <= 1'b0;
            m_axis_tdata_owner_programID    <= '0;
            m_axis_tdata_read_dependencies  <= '0;
            m_axis_tdata_write_dependencies <= '0;
            m_axis_tdest                    <= '0;
        end else if (grant_valid) begin
            m_axis_tvalid                   <= 1'b1;
            m_axis_tdata_owner_programID    <= s_axis_tdata_owner_programID[grant_idx*PW +: PW];
            m_axis_tdata_read_dependencies  <= s_axis_tdata_read_dependencies[grant_idx*MD +: MD];
            m_axis_tdata_write_dependencies <= s_axis_tdata_write_dependencies[grant_idx*MD +: MD];
            m_axis_tdest                    <= grant_idx;
        end else if (slot_free) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr                  <= '0;
            wait_cnt             <= '0;
            transactions_merged  <= '0;
            transactions_skipped <= '0;
            output_stall_cycles  <= '0;
        end else begin
            if ((ORDERED != 0) && (grant_valid || skip)) begin
                ptr <= ptr + 1'b1;
            end
            if (wait_cond && !skip) begin
                wait_cnt <= wait_cnt + 32'd1;
            end else begin
                wait_cnt <= '0;
            end
            if (grant_valid) begin
                transactions_merged <= transactions_merged + 32'd1;
            end
            if (skip) begin
                transactions_skipped <= transactions_skipped + 32'd1;
            end
            if (m_axis_tvalid && !m_axis_tready) begin
                output_stall_cycles <= output_stall_cycles + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_instance_output_merger.sv
// Scoreboard bench for instance_output_merger: three configurations (ordered,
// ordered with skip timeout 5, work-conserving) driven by directed vectors.
module tb_instance_output_merger;
    import scheduler_pkg::*;

    localparam int N  = 4;
    localparam int MD = 8;
    localparam int ND = 3;
    localparam int IW = 2;

    typedef struct {
        logic [63:0]   pid;
        logic [IW-1:0] dest;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]    s_valid [ND];
    logic [N-1:0]    s_ready [ND];
    logic [N*64-1:0] s_pid   [ND];
    logic [N*MD-1:0] s_rd    [ND];
    logic [N*MD-1:0] s_wr    [ND];
    logic            m_valid [ND];
    logic            m_ready [ND];
    logic [63:0]     m_pid   [ND];
    logic [MD-1:0]   m_rd    [ND];
    logic [MD-1:0]   m_wr    [ND];
    logic [IW-1:0]   m_dest  [ND];
    logic [31:0]     merged  [ND];
    logic [31:0]     skipped [ND];
    logic [31:0]     stalls  [ND];

    logic [63:0] src_q [ND][N][$];
    exp_t        exp_q [ND][$];
    exp_t        mon_e;

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        instance_output_merger #(
            .NUM_PARALLEL_INSTANCES (N),
            .MAX_DEPENDENCIES       (MD),
            .ORDERED                ((g == 2) ? 0 : 1),
            .SKIP_TIMEOUT_CYCLES    ((g == 1) ? 5 : 0)
        ) u_dut (
            .clk                             (clk),
            .rst                             (rst),
            .s_axis_tvalid                   (s_valid[g]),
            .s_axis_tready                   (s_ready[g]),
            .s_axis_tdata_owner_programID    (s_pid[g]),
            .s_axis_tdata_read_dependencies  (s_rd[g]),
            .s_axis_tdata_write_dependencies (s_wr[g]),
            .m_axis_tvalid                   (m_valid[g]),
            .m_axis_tready                   (m_ready[g]),
            .m_axis_tdata_owner_programID    (m_pid[g]),
            .m_axis_tdata_read_dependencies  (m_rd[g]),
            .m_axis_tdata_write_dependencies (m_wr[g]),
            .m_axis_tdest                    (m_dest[g]),
            .transactions_merged             (merged[g]),
            .transactions_skipped            (skipped[g]),
            .output_stall_cycles             (stalls[g])
        );
    end

    task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic load(input int d, input int i, input logic [63:0] pid);
        src_q[d][i].push_back(pid);
    endtask

    task automatic expect_beat(input int d, input logic [63:0] pid, input int dest);
        exp_t e;
        e.pid  = pid;
        e.dest = IW'(dest);
        exp_q[d].push_back(e);
    endtask

    // Sources hold each beat until its handshake; deps are derived from the programID.
    initial begin
        logic hs [ND][N];
        for (int d = 0; d < ND; d++) begin
            s_valid[d] = '0;
            s_pid[d]   = '0;
            s_rd[d]    = '0;
            s_wr[d]    = '0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < ND; d++)
                for (int i = 0; i < N; i++)
                    hs[d][i] = s_valid[d][i] && s_ready[d][i];
            @(posedge clk);
            #1;
            for (int d = 0; d < ND; d++) begin
                for (int i = 0; i < N; i++) begin
                    if (hs[d][i] && src_q[d][i].size() > 0) void'(src_q[d][i].pop_front());
                    s_valid[d][i] = (src_q[d][i].size() > 0);
                    if (src_q[d][i].size() > 0) begin
                        s_pid[d][i*64 +: 64] = src_q[d][i][0];
                        s_rd[d][i*MD +: MD]  = src_q[d][i][0][MD-1:0];
                        s_wr[d][i*MD +: MD]  = ~src_q[d][i][0][MD-1:0];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (!rst && m_valid[d] && m_ready[d]) begin
                if (exp_q[d].size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_beat dut%0d got pid=%0h dest=%0d want none", d, m_pid[d], m_dest[d]);
                end else begin
                    mon_e = exp_q[d].pop_front();
                    check_output($sformatf("beat_pid_dut%0d", d), m_pid[d], mon_e.pid);
                    check_output($sformatf("beat_dest_dut%0d", d), 64'(m_dest[d]), 64'(mon_e.dest));
                    check_output($sformatf("beat_deps_dut%0d", d), 64'({m_rd[d], m_wr[d]}),
                                 64'({mon_e.pid[MD-1:0], ~mon_e.pid[MD-1:0]}));
                end
            end
        end
    end

    task automatic run_burst(input int d, input int beats, output int span);
        int seen = 0;
        int cyc  = 0;
        span = -1;
        for (int k = 0; k < 100 && seen < beats; k++) begin
            @(negedge clk);
            if (m_valid[d] && m_ready[d]) seen++;
            if (seen > 0) cyc++;
        end
        if (seen == beats) span = cyc;
    endtask

    task automatic wait_mvalid(input int d, input string name);
        int k = 0;
        while (!m_valid[d] && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_output(name, 64'(m_valid[d]), 64'd1);
    endtask

    task automatic drain(input int d);
        int k = 0;
        while (exp_q[d].size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        check_output($sformatf("drain_dut%0d", d), 64'(exp_q[d].size()), 64'd0);
    endtask

    task automatic check_counters(input int d, input string tag, input int m, input int sk, input int st);
        check_output($sformatf("%s_merged", tag), 64'(merged[d]), 64'(m));
        check_output($sformatf("%s_skipped", tag), 64'(skipped[d]), 64'(sk));
        check_output($sformatf("%s_stalls", tag), 64'(stalls[d]), 64'(st));
    endtask

    task automatic apply_stimulus();
        int span;
        int viol;
        int cyc;
        int k;
        bit hs_ok;

        for (int d = 0; d < ND; d++) m_ready[d] = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check_output($sformatf("rst_valid_dut%0d", d), 64'(m_valid[d]), 64'd0);
            check_output($sformatf("rst_data_dut%0d", d), m_pid[d] | 64'(m_dest[d]), 64'd0);
            check_counters(d, $sformatf("rst_dut%0d", d), 0, 0, 0);
        end

        // Ordered drain: two beats per instance come back interleaved by instance.
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++)
                expect_beat(0, 64'(16 * (i + 1) + r), i);
        for (int i = 0; i < N; i++) begin
            load(0, i, 64'(16 * (i + 1)));
            load(0, i, 64'(16 * (i + 1) + 1));
        end
        run_burst(0, 8, span);
        check_output("ordered_back_to_back", 64'(span), 64'd8);
        @(negedge clk);
        check_output("ordered_merged", 64'(merged[0]), 64'd8);

        // Ordered wait without skip: instance 0 idle blocks everyone.
        load(0, 1, 64'hB1);
        load(0, 2, 64'hB2);
        load(0, 3, 64'hB3);
        viol = 0;
        repeat (50) begin
            @(negedge clk);
            if (m_valid[0] || s_ready[0] != '0) viol++;
        end
        check_output("ordered_wait_idle", 64'(viol), 64'd0);
        expect_beat(0, 64'h0A, 0);
        expect_beat(0, 64'hB1, 1);
        expect_beat(0, 64'hB2, 2);
        expect_beat(0, 64'hB3, 3);
        load(0, 0, 64'h0A);
        hs_ok = 1'b0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (s_valid[0][0] && s_ready[0][0]) begin
                hs_ok = 1'b1;
                break;
            end
        end
        check_output("wait_inst0_handshake", 64'(hs_ok), 64'd1);
        @(negedge clk);
        check_output("wait_latency_valid", 64'(m_valid[0]), 64'd1);
        check_output("wait_latency_pid", m_pid[0], 64'h0A);
        drain(0);

        // Skip timeout: instance 0 never valid, instance 1 accepted on cycle 6.
        expect_beat(1, 64'h55, 1);
        load(1, 1, 64'h55);
        k = 0;
        while (!s_valid[1][1] && k < 20) begin
            @(negedge clk);
            k++;
        end
        cyc = 0;
        for (k = 0; k < 20; k++) begin
            cyc++;
            if (s_valid[1][1] && s_ready[1][1]) break;
            @(negedge clk);
        end
        check_output("skip_accept_cycle", 64'(cyc), 64'd6);
        @(negedge clk);
        check_output("skip_count", 64'(skipped[1]), 64'd1);
        check_output("skip_merged", 64'(merged[1]), 64'd1);
        drain(1);

        // Work-conserving: instances 2 and 3 alternate at full rate.
        for (int r = 0; r < 3; r++) begin
            expect_beat(2, 64'(8'hC0 + r), 2);
            expect_beat(2, 64'(8'hD0 + r), 3);
            load(2, 2, 64'(8'hC0 + r));
            load(2, 3, 64'(8'hD0 + r));
        end
        run_burst(2, 6, span);
        check_output("wc_back_to_back", 64'(span), 64'd6);
        @(negedge clk);
        check_output("wc_merged", 64'(merged[2]), 64'd6);

        // Backpressure: hold a beat for 10 cycles, then release.
        @(posedge clk);
        #1 m_ready[2] = 1'b0;
        expect_beat(2, 64'hE0, 0);
        expect_beat(2, 64'hE1, 1);
        load(2, 0, 64'hE0);
        load(2, 1, 64'hE1);
        wait_mvalid(2, "bp_first_valid");
        viol = 0;
        for (int j = 0; j < 10; j++) begin
            if (j > 0) @(negedge clk);
            if (!m_valid[2] || m_pid[2] != 64'hE0 || m_dest[2] != 2'd0 || s_ready[2] != '0) viol++;
        end
        check_output("bp_stable", 64'(viol), 64'd0);
        @(posedge clk);
        #1 m_ready[2] = 1'b1;
        @(negedge clk);
        check_output("bp_stall_cycles", 64'(stalls[2]), 64'd10);
        drain(2);
        check_output("bp_merged", 64'(merged[2]), 64'd8);

        // Reset mid-stream discards the held beat and restarts at instance 0.
        @(posedge clk);
        #1 m_ready[0] = 1'b0;
        load(0, 0, 64'hF0);
        wait_mvalid(0, "rst_mid_held_valid");
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_output("rst_mid_valid", 64'(m_valid[0]), 64'd0);
        check_counters(0, "rst_mid", 0, 0, 0);
        @(posedge clk);
        #1 m_ready[0] = 1'b1;
        expect_beat(0, 64'h70, 0);
        expect_beat(0, 64'h71, 1);
        load(0, 1, 64'h71);
        load(0, 0, 64'h70);
        drain(0);
        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) drain(d);
    endtask

    initial begin
        apply_stimulus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
